frame_renderer: RTL and testbench

Scans the J.O.S.H. Jump playfield once per frame and emits one VGA pixel write per cycle (x, y, colour, plot) into the VGA adapter. It sits directly downstream of the game datapath. Per column, it reads the wall bitmap through a column-addressed read port and overlays the 4×6 player sprite at the player's position, which is snapshotted at frame start. Handshake is start / busy / done, so the game FSM can sequence erase, update and redraw.

---
 rtl/josh_pkg.sv | 27 ++
 rtl/sprite_hit.sv | 23 ++
 rtl/frame_renderer.sv | 118 +++++++++++
 tb/tb_frame_renderer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/josh_pkg.sv
// Shared playfield geometry, colour codes and renderer state encoding for the
// J.O.S.H. Jump display path.
package josh_pkg;

  localparam int PLAY_W = 120;
  localparam int PLAY_H = 100;
  localparam int X_OFF  = 20;
  localparam int Y_OFF  = 10;
  localparam int DUDE_W = 4;
  localparam int DUDE_H = 6;

  localparam logic [6:0] LAST_COL = 7'(PLAY_W - 1);
  localparam logic [6:0] LAST_ROW = 7'(PLAY_H - 1);

  localparam logic [2:0] BG   = 3'b000;
  localparam logic [2:0] WALL = 3'b111;
  localparam logic [2:0] DUDE = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    DRAW,
    FIN
  } render_state_t;

endpackage

// File: rtl/sprite_hit.sv
// Combinational test of whether a playfield cell lies under the 4x6 player
// sprite whose top-left corner is (h, v).
module sprite_hit
  import josh_pkg::*;
(
  input  logic [6:0] col,
  input  logic [6:0] row,
  input  logic [6:0] h,
  input  logic [6:0] v,
  output logic       hit
);

  logic [7:0] w_h_end;
  logic [7:0] w_v_end;

  // Bounds are one bit wider so a sprite at the right/bottom edge cannot wrap.
  assign w_h_end = {1'b0, h} + 8'(DUDE_W - 1);
  assign w_v_end = {1'b0, v} + 8'(DUDE_H - 1);

  assign hit = (col >= h) && ({1'b0, col} <= w_h_end) &&
               (row >= v) && ({1'b0, row} <= w_v_end);

endmodule

// File: rtl/frame_renderer.sv
// Scans the playfield column by column, overlays the player sprite on the wall
// bitmap and emits one registered VGA pixel write per DRAW cycle.
module frame_renderer
  import josh_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [6:0]        hdude,
  input  logic [6:0]        vdude,
  output logic [6:0]        col_addr,
  input  logic [PLAY_H-1:0] col_data,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic              done
);

  render_state_t     r_state;
  render_state_t     w_next;
  logic [6:0]        r_col;
  logic [6:0]        r_row;
  logic [6:0]        r_h;
  logic [6:0]        r_v;
  logic [PLAY_H-1:0] r_buf;
  logic [7:0]        r_vga_x;
  logic [6:0]        r_vga_y;
  logic [2:0]        r_colour;
  logic              r_plot;
  logic              r_done;
  logic              w_hit;
  logic [2:0]        w_colour;

  sprite_hit u_sprite_hit (
    .col (r_col),
    .row (r_row),
    .h   (r_h),
    .v   (r_v),
    .hit (w_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // NOTE: defaults first, so no path through the case leaves w_next unassigned
  // and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = DRAW;
      DRAW:    if (r_row == LAST_ROW) w_next = (r_col == LAST_COL) ? FIN : FETCH;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_colour = BG;
    if (w_hit)             w_colour = DUDE;
    else if (r_buf[r_row]) w_colour = WALL;
  end

  // NOTE: the column buffer is a plain flop vector, not a RAM, so it is cleared
  // by the async reset along with the rest of the datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col    <= '0;
      r_row    <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_buf    <= '0;
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= BG;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= (r_state == DRAW);
      r_done <= (r_state == FIN);
      unique case (r_state)
        IDLE: if (start) begin
          r_h   <= hdude;
          r_v   <= vdude;
          r_col <= '0;
        end
        LOAD: begin
          r_buf <= col_data;
          r_row <= '0;
        end
        DRAW: begin
          r_vga_x  <= {1'b0, r_col} + 8'(X_OFF);
          r_vga_y  <= r_row + 7'(Y_OFF);
          r_colour <= w_colour;
          if (r_row != LAST_ROW)      r_row <= r_row + 7'd1;
          else if (r_col != LAST_COL) r_col <= r_col + 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign col_addr   = r_col;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_frame_renderer.sv
// Self-checking bench for frame_renderer: table-driven frames, hand-written
// multi-cycle corner cases and a random frame against an image-level model.
module tb_frame_renderer;

  localparam int W         = 120;
  localparam int H         = 100;
  localparam int XO        = 20;
  localparam int YO        = 10;
  localparam int LAST_PLOT = 12241;
  localparam int DONE_CYC  = 12242;
  localparam int TIMEOUT   = 13000;
  localparam logic [2:0] C_BG   = 3'b000;
  localparam logic [2:0] C_WALL = 3'b111;
  localparam logic [2:0] C_DUDE = 3'b110;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  hdude = '0;
  logic [6:0]  vdude = '0;
  logic [6:0]  col_addr;
  logic [99:0] col_data = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  frame_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .hdude      (hdude),
    .vdude      (vdude),
    .col_addr   (col_addr),
    .col_data   (col_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  // Wall memory with a one-cycle read latency.
  logic [99:0] wall [W];
  always @(posedge clk) col_data <= (int'(col_addr) < W) ? wall[col_addr] : '0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [2:0] pix  [W][H];
  int         hits [W][H];
  int n_plots, n_oor, plot_err, busy_err, done_cyc;
  int pre_rst_plot, post_rst_plot, post_rst_busy;

  task automatic clear_walls();
    for (int c = 0; c < W; c++) wall[c] = '0;
  endtask

  // Caller drives start=1 before calling; the next posedge is cycle 0.
  // Each negedge after edge n is sampled as cycle n+1.
  task automatic capture(input int chg_cyc, input logic [6:0] chg_h,
                         input int pulse_cyc, input int rst_cyc, input bit chain);
    int cyc, k, off, xi, yi;
    bit exp_plot;
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++) begin
        pix[c][r]  = C_BG;
        hits[c][r] = 0;
      end
    n_plots = 0; n_oor = 0; plot_err = 0; busy_err = 0; done_cyc = -1;
    @(posedge clk);
    cyc = 0;
    while (cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == chg_cyc) hdude = chg_h;
      if (cyc == pulse_cyc) start = 1'b1;
      if (cyc == pulse_cyc + 1) start = 1'b0;
      if (cyc == rst_cyc) begin
        pre_rst_plot = int'(vga_plot);
        resetn = 1'b0;
        #1;
        post_rst_plot = int'(vga_plot);
        post_rst_busy = int'(busy);
        break;
      end
      if (busy !== (cyc <= LAST_PLOT)) busy_err++;
      k   = (cyc - 4) / 102;
      off = (cyc - 4) % 102;
      exp_plot = (cyc >= 4) && (cyc <= LAST_PLOT) && (off < H);
      if (vga_plot !== exp_plot) plot_err++;
      if (vga_plot === 1'b1) begin
        n_plots++;
        xi = int'(vga_x) - XO;
        yi = int'(vga_y) - YO;
        if (exp_plot && (xi != k || yi != off)) plot_err++;
        if (xi < 0 || xi >= W || yi < 0 || yi >= H) n_oor++;
        else begin
          pix[xi][yi] = vga_colour;
          hits[xi][yi]++;
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        if (chain) start = 1'b1;
        break;
      end
    end
  endtask

  // Reference image: the sprite rectangle covers walls, walls cover background.
  function automatic logic [2:0] model_px(int c, int r, int h, int v);
    if (c >= h && c < h + 4 && r >= v && r < v + 6) return C_DUDE;
    if (wall[c][r]) return C_WALL;
    return C_BG;
  endfunction

  task automatic check_frame(input string tag, input int h, input int v,
                             output int n_dude, output int n_wall);
    int mism = 0;
    n_dude = 0;
    n_wall = 0;
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++) begin
        if (hits[c][r] != 1 || pix[c][r] !== model_px(c, r, h, v)) mism++;
        if (hits[c][r] == 1 && pix[c][r] == C_DUDE) n_dude++;
        if (hits[c][r] == 1 && pix[c][r] == C_WALL) n_wall++;
      end
    check({tag, "_done_cycle"}, done_cyc, DONE_CYC);
    check({tag, "_plots"}, n_plots, W * H);
    check({tag, "_plot_timing"}, plot_err, 0);
    check({tag, "_busy_window"}, busy_err, 0);
    check({tag, "_out_of_field"}, n_oor, 0);
    check({tag, "_pixel_mismatch"}, mism, 0);
  endtask

  typedef struct {
    int         h, v;
    int         wc0, wr0, wc1, wr1;
    int         pc, pr;
    logic [2:0] pexp;
    int         exp_dude, exp_wall;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    int n_dude, n_wall, n_done;
    logic [127:0] rnd;
    int rh, rv;

    vecs[0] = '{h: 0,   v: 0,  wc0: -1, wr0: -1, wc1: -1,  wr1: -1, pc: 3,   pr: 5,
                pexp: C_DUDE, exp_dude: 24, exp_wall: 0};
    vecs[1] = '{h: 50,  v: 40, wc0: 5,  wr0: 99, wc1: 51,  wr1: 42, pc: 5,   pr: 99,
                pexp: C_WALL, exp_dude: 24, exp_wall: 1};
    vecs[2] = '{h: 118, v: 97, wc0: 0,  wr0: 0,  wc1: 118, wr1: 98, pc: 118, pr: 98,
                pexp: C_DUDE, exp_dude: 6,  exp_wall: 1};

    clear_walls();
    repeat (3) @(negedge clk);
    check("rst_col_addr", int'(col_addr), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Table frames, chained: each next start is sampled in the previous done cycle.
    for (int i = 0; i < 3; i++) begin
      clear_walls();
      if (vecs[i].wc0 >= 0) wall[vecs[i].wc0][vecs[i].wr0] = 1'b1;
      if (vecs[i].wc1 >= 0) wall[vecs[i].wc1][vecs[i].wr1] = 1'b1;
      hdude = 7'(vecs[i].h);
      vdude = 7'(vecs[i].v);
      start = 1'b1;
      capture(-1, '0, -1, -1, i < 2);
      check_frame($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, n_dude, n_wall);
      check($sformatf("vec%0d_dude_count", i), n_dude, vecs[i].exp_dude);
      check($sformatf("vec%0d_wall_count", i), n_wall, vecs[i].exp_wall);
      check($sformatf("vec%0d_probe", i), int'(pix[vecs[i].pc][vecs[i].pr]), int'(vecs[i].pexp));
    end

    // Position change and extra start mid-frame must not disturb the frame.
    repeat (3) @(negedge clk);
    clear_walls();
    hdude = 7'd10;
    vdude = 7'd30;
    start = 1'b1;
    capture(500, 7'd60, 600, -1, 1'b0);
    check_frame("snapshot", 10, 30, n_dude, n_wall);
    check("snapshot_dude_count", n_dude, 24);
    n_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check("ignored_start_activity", n_done, 0);

    // Asynchronous reset in the middle of a plotting column.
    hdude = 7'd0;
    vdude = 7'd0;
    start = 1'b1;
    capture(-1, '0, -1, 5010, 1'b0);
    check("midrst_plot_before", pre_rst_plot, 1);
    check("midrst_plot_after", post_rst_plot, 0);
    check("midrst_busy_after", post_rst_busy, 0);
    check("midrst_no_done", done_cyc, -1);
    @(negedge clk);
    check("midrst_col_addr", int'(col_addr), 0);
    resetn = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check("midrst_quiet_after", n_done, 0);

    // Random walls and sprite position after reset release.
    for (int c = 0; c < W; c++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      wall[c] = rnd[99:0];
    end
    rh = int'($urandom_range(0, W - 1));
    rv = int'($urandom_range(0, H - 1));
    hdude = 7'(rh);
    vdude = 7'(rv);
    start = 1'b1;
    capture(-1, '0, -1, -1, 1'b0);
    check_frame("random", rh, rv, n_dude, n_wall);
    check("random_dude_count", n_dude,
          ((rh + 4 > W) ? W - rh : 4) * ((rv + 6 > H) ? H - rv : 6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
